// File: rtl/param_proc_pkg.sv
// Shared encodings for param_proc_core: opcodes, ALU functs, instruction field positions, FSM states.
// Optional single-step state exists only when PARAM_PROC_SINGLE_STEP_EN is defined.
package param_proc_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_MOVE  = 2'b10;
  localparam logic [1:0] OP_ALU   = 2'b11;

  localparam logic [1:0] F_ADD = 2'b00;
  localparam logic [1:0] F_SUB = 2'b01;
  localparam logic [1:0] F_AND = 2'b10;
  localparam logic [1:0] F_NOT = 2'b11;

  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int X_HI   = 5;
  localparam int X_LO   = 4;
  localparam int Y_HI   = 3;
  localparam int Y_LO   = 2;
  localparam int F_HI   = 1;
  localparam int F_LO   = 0;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_EXEC      = 3'd2;
  localparam logic [2:0] S_EXEC_IMM  = 3'd3;
`ifdef PARAM_PROC_SINGLE_STEP_EN
  localparam logic [2:0] S_STEP_WAIT = 3'd4;
`endif

endpackage

// File: rtl/param_proc_alu.sv
// Combinational DATA_W ALU: ADD/SUB drive carry (carry-out / borrow), AND/NOT report carry=0.
// Zero latency, no flow control.
module param_proc_alu
  import param_proc_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        funct,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (funct)
      F_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      // Extended subtraction wraps to all-ones in the top bit exactly when a < b.
      F_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      F_AND:   result = a & b;
      F_NOT:   result = ~b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/param_proc_core.sv
// Button-driven 4-register processor with program memory; PARAM_PROC_SINGLE_STEP_EN adds a STEP_WAIT pause per run instruction.
// Latency: button pulse 3 cycles after press, 1 cycle per immediate op, 2 cycles per stored op; presses while busy are dropped.
module param_proc_core
  import param_proc_pkg::*;
#(
  parameter  int DATA_W     = 4,
  parameter  int PROG_DEPTH = 16,
  localparam int PA_W       = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [7:0]        sw,
  input  logic [1:0]        btn,
  input  logic              prog_we,
  input  logic [PA_W-1:0]   prog_addr,
  input  logic [7:0]        prog_data,
  input  logic [PA_W:0]     prog_len,
  output logic [DATA_W-1:0] led,
  output logic              carry,
  output logic              busy,
  output logic [PA_W-1:0]   pc
);

  logic [1:0]        btn_s1, btn_s2, btn_prev, btn_pulse;
  logic              user_pulse, run_pulse;
  logic [2:0]        state;
  logic [7:0]        ir;
  logic [PA_W:0]     len_q;
  logic [PA_W:0]     pc_inc;
  logic              last_instr;
  logic [7:0]        mem [PROG_DEPTH];
  logic [DATA_W-1:0] rf [4];

  logic [1:0]        op, x_idx, y_idx, funct;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              commit;

  // Two-flop synchroniser, then a registered rising-edge pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      btn_s1    <= '0;
      btn_s2    <= '0;
      btn_prev  <= '0;
      btn_pulse <= '0;
    end else begin
      btn_s1    <= btn;
      btn_s2    <= btn_s1;
      btn_prev  <= btn_s2;
      btn_pulse <= btn_s2 & ~btn_prev;
    end
  end

  assign user_pulse = btn_pulse[0];
  assign run_pulse  = btn_pulse[1];

  // Program memory is deliberately not reset so a loaded program survives clr.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  assign op     = ir[OP_HI:OP_LO];
  assign x_idx  = ir[X_HI:X_LO];
  assign y_idx  = ir[Y_HI:Y_LO];
  assign funct  = ir[F_HI:F_LO];
  assign commit = (state == S_EXEC) || (state == S_EXEC_IMM);
  assign busy   = (state != S_IDLE);

  always_comb begin
    imm_ext = '0;
    imm_ext[3:0] = ir[IMM_HI:IMM_LO];
  end

  param_proc_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (rf[x_idx]),
    .b      (rf[y_idx]),
    .funct  (funct),
    .result (alu_res),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      led   <= '0;
      carry <= 1'b0;
    end else if (commit) begin
      case (op)
        OP_LOAD:  rf[x_idx] <= imm_ext;
        OP_STORE: led <= rf[x_idx];
        OP_MOVE:  rf[x_idx] <= rf[y_idx];
        default: begin
          rf[x_idx] <= alu_res;
          if (funct == F_ADD || funct == F_SUB) carry <= alu_carry;
        end
      endcase
    end
  end

  assign pc_inc     = {1'b0, pc} + (PA_W + 1)'(1);
  assign last_instr = (pc_inc == len_q);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      len_q <= '0;
    end else begin
      case (state)
        // Run takes priority; a run with zero length swallows both pulses.
        S_IDLE: begin
          if (run_pulse) begin
            if (prog_len != '0) begin
              len_q <= prog_len;
              pc    <= '0;
              state <= S_FETCH;
            end
          end else if (user_pulse) begin
            ir    <= sw;
            state <= S_EXEC_IMM;
          end
        end
        S_FETCH: begin
          ir    <= mem[pc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (last_instr) begin
            state <= S_IDLE;
          end else begin
            pc <= pc_inc[PA_W-1:0];
`ifdef PARAM_PROC_SINGLE_STEP_EN
            state <= S_STEP_WAIT;
`else
            state <= S_FETCH;
`endif
          end
        end
        S_EXEC_IMM: state <= S_IDLE;
`ifdef PARAM_PROC_SINGLE_STEP_EN
        S_STEP_WAIT: begin
          if (run_pulse)       state <= S_IDLE;
          else if (user_pulse) state <= S_FETCH;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_proc_core.sv
// Directed self-checking bench for param_proc_core (DATA_W=4, PROG_DEPTH=16).
// Register contents are observed through STORE onto led.
module tb_param_proc_core;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] sw;
  logic [1:0] btn;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [4:0] prog_len;
  logic [3:0] led;
  logic       carry;
  logic       busy;
  logic [3:0] pc;

  int errors = 0;
  int checks = 0;

  param_proc_core #(.DATA_W(4), .PROG_DEPTH(16)) dut (
    .clk       (clk),
    .clr       (clr),
    .sw        (sw),
    .btn       (btn),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .led       (led),
    .carry     (carry),
    .busy      (busy),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic press(input int idx);
    @(posedge clk); #1;
    btn[idx] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    btn[idx] = 1'b0;
  endtask

  // Wait for busy to rise, then count the cycles it stays high.
  task automatic wait_done(input string name, output int cyc);
    int t;
    cyc = 0;
    t = 0;
    while (busy !== 1'b1 && t < 12) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s: busy never rose", name);
    end else begin
      while (busy === 1'b1 && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      if (busy === 1'b1) begin
        checks++; errors++;
        $display("FAIL %s: busy stuck high", name);
      end
    end
  endtask

  task automatic exec_word(input logic [7:0] w, output int cyc);
    sw = w;
    press(0);
    wait_done("exec_word", cyc);
  endtask

  task automatic write_prog(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic run_prog(input logic [4:0] len, output int cyc);
    prog_len = len;
    press(1);
    wait_done("run_prog", cyc);
  endtask

  task automatic test_reset;
    clr = 1'b1; sw = '0; btn = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    repeat (3) @(negedge clk);
    checks++; if (led !== 4'd0)  begin errors++; $display("FAIL reset_led: got %0d want 0", led); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", carry); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (pc !== 4'd0)   begin errors++; $display("FAIL reset_pc: got %0d want 0", pc); end
    clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_user_exec;
    int cyc;
    exec_word(8'h01, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL load_busy_cycles: got %0d want 1", cyc); end
    exec_word(8'h40, cyc);
    checks++; if (led !== 4'd1) begin errors++; $display("FAIL user_store_led: got %0d want 1", led); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL store_busy_cycles: got %0d want 1", cyc); end
  endtask

  task automatic test_run;
    int cyc;
    write_prog(4'd0, 8'hC0);
    write_prog(4'd1, 8'h90);
    write_prog(4'd2, 8'h50);
    run_prog(5'd3, cyc);
    checks++; if (led !== 4'd2)  begin errors++; $display("FAIL run_led: got %0d want 2", led); end
    checks++; if (pc !== 4'd2)   begin errors++; $display("FAIL run_pc: got %0d want 2", pc); end
    checks++; if (cyc !== 6)     begin errors++; $display("FAIL run_cycles: got %0d want 6", cyc); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL run_carry: got %b want 0", carry); end
  endtask

  task automatic test_alu_carry;
    int cyc;
    exec_word(8'h0F, cyc);
    exec_word(8'h11, cyc);
    exec_word(8'hC4, cyc);
    exec_word(8'h40, cyc);
    checks++; if (led !== 4'd0)   begin errors++; $display("FAIL add_wrap_led: got %0d want 0", led); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL add_carry: got %b want 1", carry); end
    exec_word(8'hC5, cyc);
    exec_word(8'h40, cyc);
    checks++; if (led !== 4'd15)  begin errors++; $display("FAIL sub_wrap_led: got %0d want 15", led); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL sub_borrow: got %b want 1", carry); end
    exec_word(8'h26, cyc);
    exec_word(8'h3C, cyc);
    exec_word(8'hEE, cyc);
    exec_word(8'h60, cyc);
    checks++; if (led !== 4'd4)   begin errors++; $display("FAIL and_led: got %0d want 4", led); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL and_keeps_carry: got %b want 1", carry); end
    exec_word(8'hFB, cyc);
    exec_word(8'h70, cyc);
    checks++; if (led !== 4'd11)  begin errors++; $display("FAIL not_led: got %0d want 11", led); end
    exec_word(8'hE8, cyc);
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL add_no_carry: got %b want 0", carry); end
    exec_word(8'h60, cyc);
    checks++; if (led !== 4'd8)   begin errors++; $display("FAIL add_no_carry_led: got %0d want 8", led); end
  endtask

  task automatic test_len_zero;
    int seen;
    seen = 0;
    prog_len = 5'd0;
    press(1);
    repeat (10) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL len_zero_busy: got %0d want 0", seen); end
  endtask

`ifndef PARAM_PROC_SINGLE_STEP_EN
  task automatic test_press_during_run;
    int cyc, t, seen;
    exec_word(8'h01, cyc);
    prog_len = 5'd3;
    sw = 8'h0F;
    @(posedge clk); #1;
    btn[1] = 1'b1;
    t = 0;
    while (busy !== 1'b1 && t < 12) begin
      @(negedge clk);
      t++;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_press_start: busy=%b want 1", busy); end
    btn[1] = 1'b0;
    btn[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    btn[0] = 1'b0;
    t = 0;
    while (busy === 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1;
    end
    checks++; if (seen !== 0)  begin errors++; $display("FAIL busy_press_restart: got %0d want 0", seen); end
    checks++; if (led !== 4'd2) begin errors++; $display("FAIL busy_press_led: got %0d want 2", led); end
    exec_word(8'h40, cyc);
    checks++; if (led !== 4'd2) begin errors++; $display("FAIL busy_press_r0: got %0d want 2", led); end
  endtask

  task automatic test_clr_mid_run;
    int cyc, t;
    prog_len = 5'd3;
    press(1);
    t = 0;
    while (busy !== 1'b1 && t < 12) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    checks++; if (led !== 4'd0)  begin errors++; $display("FAIL clr_led: got %0d want 0", led); end
    checks++; if (pc !== 4'd0)   begin errors++; $display("FAIL clr_pc: got %0d want 0", pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", busy); end
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    exec_word(8'h01, cyc);
    run_prog(5'd3, cyc);
    checks++; if (led !== 4'd2) begin errors++; $display("FAIL post_clr_led: got %0d want 2", led); end
    checks++; if (pc !== 4'd2)  begin errors++; $display("FAIL post_clr_pc: got %0d want 2", pc); end
  endtask
`else
  task automatic test_single_step;
    int cyc;
    write_prog(4'd0, 8'hC0);
    write_prog(4'd1, 8'h90);
    write_prog(4'd2, 8'h50);
    exec_word(8'h01, cyc);
    exec_word(8'h40, cyc);
    prog_len = 5'd3;
    press(1);
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL step1_busy: got %b want 1", busy); end
    checks++; if (pc !== 4'd1)   begin errors++; $display("FAIL step1_pc: got %0d want 1", pc); end
    press(0);
    repeat (6) @(negedge clk);
    checks++; if (pc !== 4'd2)   begin errors++; $display("FAIL step2_pc: got %0d want 2", pc); end
    checks++; if (led !== 4'd1)  begin errors++; $display("FAIL step2_led: got %0d want 1", led); end
    press(1);
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL step_abort_busy: got %b want 0", busy); end
    checks++; if (led !== 4'd1)  begin errors++; $display("FAIL step_abort_led: got %0d want 1", led); end
    exec_word(8'h50, cyc);
    checks++; if (led !== 4'd2)  begin errors++; $display("FAIL step_partial_r1: got %0d want 2", led); end
    exec_word(8'h15, cyc);
    exec_word(8'h50, cyc);
    exec_word(8'h01, cyc);
    checks++; if (led !== 4'd5)  begin errors++; $display("FAIL step_preload_led: got %0d want 5", led); end
    press(1);
    repeat (6) @(negedge clk);
    press(0);
    repeat (6) @(negedge clk);
    press(0);
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL step_full_busy: got %b want 0", busy); end
    checks++; if (led !== 4'd2)  begin errors++; $display("FAIL step_full_led: got %0d want 2", led); end
    checks++; if (pc !== 4'd2)   begin errors++; $display("FAIL step_full_pc: got %0d want 2", pc); end
  endtask
`endif

  initial begin
    test_reset();
    test_user_exec();
`ifndef PARAM_PROC_SINGLE_STEP_EN
    test_run();
`endif
    test_alu_carry();
    test_len_zero();
`ifndef PARAM_PROC_SINGLE_STEP_EN
    test_press_during_run();
    test_clr_mid_run();
`else
    test_single_step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
